// File: rtl/cntr_prog_timer_if.sv
// Bus bundle for the programmable counter/timer: control inputs from user
// logic and the count/done/busy status returned by the timer.
interface cntr_prog_timer_if #(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 4
);
   logic               en;
   logic [WIDTH-1:0]   limit;
   logic               load;
   logic [PRESC_W-1:0] presc;
   logic               mode_dir;
   logic               mode_oneshot;
   logic               start;
   logic [WIDTH-1:0]   count;
   logic               done;
   logic               busy;

   modport master (
      output en, limit, load, presc, mode_dir, mode_oneshot, start,
      input  count, done, busy
   );

   modport slave (
      input  en, limit, load, presc, mode_dir, mode_oneshot, start,
      output count, done, busy
   );
endinterface

// File: rtl/cntr_prog_timer.sv
// Programmable terminal-count counter/timer with prescaler, up/down
// direction, one-shot or auto-reload mode and a latched limit register.
module cntr_prog_timer #(
   parameter int WIDTH       = 8,
   parameter int PRESC_W     = 4,
   parameter int SYNC_STAGES = 2
) (
   input logic               clk,
   input logic               rst_n,
   cntr_prog_timer_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     count_q, count_d;
   logic                 done_q, done_d;
   logic [WIDTH-1:0]     limit_q, limit_d;
   logic [PRESC_W-1:0]   presc_cnt_q, presc_cnt_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic                 dir_q, dir_d;
   logic                 oneshot_q, oneshot_d;
   logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;

   logic                 en_s;
   logic                 tick;
   logic                 terminal;

   assign en_s = en_sync_q[SYNC_STAGES-1];

   // Shift the asynchronous enable through the synchroniser chain.
   always_comb begin
      en_sync_d[0] = bus.en;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         en_sync_d[i] = en_sync_q[i-1];
      end
   end

   // Tick and terminal detection for the currently running configuration.
   always_comb begin
      tick     = 1'b0;
      terminal = 1'b0;
      if (state_q == ST_RUN) begin
         tick = (presc_cnt_q == presc_q);
      end
      if (dir_q) begin
         terminal = (count_q == '0);
      end else begin
         terminal = (count_q >= limit_q);
      end
   end

   // Next-state logic: enable loss beats start, start beats counting.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      done_d      = 1'b0;
      limit_d     = limit_q;
      presc_cnt_d = presc_cnt_q;
      presc_d     = presc_q;
      dir_d       = dir_q;
      oneshot_d   = oneshot_q;

      if (bus.load) begin
         limit_d = bus.limit;
      end

      if (!en_s) begin
         state_d     = ST_IDLE;
         count_d     = '0;
         presc_cnt_d = '0;
      end else if (bus.start) begin
         state_d     = ST_RUN;
         presc_cnt_d = '0;
         dir_d       = bus.mode_dir;
         oneshot_d   = bus.mode_oneshot;
         presc_d     = bus.presc;
         count_d     = bus.mode_dir ? limit_q : '0;
      end else if (state_q == ST_RUN) begin
         if (tick) begin
            presc_cnt_d = '0;
            if (terminal) begin
               done_d = 1'b1;
               if (oneshot_q) begin
                  state_d = ST_HOLD;
               end else begin
                  count_d = dir_q ? limit_q : '0;
               end
            end else begin
               count_d = dir_q ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
            end
         end else begin
            presc_cnt_d = presc_cnt_q + PRESC_W'(1);
         end
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         done_q      <= 1'b0;
         limit_q     <= '0;
         presc_cnt_q <= '0;
         presc_q     <= '0;
         dir_q       <= 1'b0;
         oneshot_q   <= 1'b0;
         en_sync_q   <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         done_q      <= done_d;
         limit_q     <= limit_d;
         presc_cnt_q <= presc_cnt_d;
         presc_q     <= presc_d;
         dir_q       <= dir_d;
         oneshot_q   <= oneshot_d;
         en_sync_q   <= en_sync_d;
      end
   end

   assign bus.count = count_q;
   assign bus.done  = done_q;
   assign bus.busy  = (state_q == ST_RUN);

endmodule
